// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// No logic, so no latency.
// No flow control here; consumers define their own.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // Two-bit state leaves spare encodings; the FSM sends those back to IDLE.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data array: synchronous write, combinational read, no reset.
// Read is same-cycle; write lands on the rising edge.
// No backpressure; the owning stage sequences all accesses.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Store commits at the edge when enabled; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: performs loads/stores and owns the MEM/WB register.
// Non-memory ops take 1 cycle; loads/stores take MEM_LAT cycles.
// Raises stall for MEM_LAT-1 cycles per memop so upstream holds the op.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] store_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite_in,
  input  logic [REG_W-1:0]  Rd_in,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_regwrite
);

  // Counter only needs to hold MEM_LAT-2; keep at least one bit.
  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam bit MULTI = (MEM_LAT > 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Holding registers: the op captured when the access started.
  logic [DATA_W-1:0]  h_alu;
  logic [DATA_W-1:0]  h_sdata;
  logic               h_load;
  logic               h_store;
  logic               h_regwrite;
  logic [REG_W-1:0]   h_rd;

  logic               memop;
  logic               is_store;
  logic               is_load;
  logic               busy;
  logic               done;
  logic               start;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  // Store wins when both MemRead and MemWrite are set.
  assign memop    = valid_in & (MemRead | MemWrite);
  assign is_store = valid_in & MemWrite;
  assign is_load  = valid_in & MemRead & ~MemWrite;
  assign busy     = (state == BUSY);
  assign done     = busy && (cnt == '0);
  assign start    = (state == IDLE) && MULTI && memop;

  // Memory port follows the held op while busy, the live inputs otherwise.
  always_comb begin
    mem_addr  = busy ? h_alu[ADDR_W-1:0] : ALUOut[ADDR_W-1:0];
    mem_wdata = busy ? h_sdata : store_data;
    mem_we    = 1'b0;
    if (!reset) begin
      if (done)
        mem_we = h_store;
      else if ((state == IDLE) && !start)
        mem_we = is_store;
    end
  end

  // Stall covers the start cycle and every busy cycle except the last.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = MULTI && memop;
      BUSY:    stall = (cnt != '0);
      default: stall = 1'b0;
    endcase
  end

  data_memory #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // FSM, latency counter, holding registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      h_alu       <= '0;
      h_sdata     <= '0;
      h_load      <= 1'b0;
      h_store     <= 1'b0;
      h_regwrite  <= 1'b0;
      h_rd        <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            h_alu       <= ALUOut;
            h_sdata     <= store_data;
            h_load      <= MemRead & ~MemWrite;
            h_store     <= MemWrite;
            h_regwrite  <= RegWrite_in & ~MemWrite;
            h_rd        <= Rd_in;
            cnt         <= CNT_W'(MEM_LAT - 2);
            state       <= BUSY;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else begin
            wb_valid    <= valid_in;
            wb_rd       <= Rd_in;
            wb_regwrite <= RegWrite_in & valid_in & ~MemWrite;
            wb_data     <= is_load ? mem_rdata : ALUOut;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt         <= cnt - 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else begin
            wb_valid    <= 1'b1;
            wb_rd       <= h_rd;
            wb_regwrite <= h_regwrite;
            wb_data     <= h_load ? mem_rdata : h_alu;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          wb_valid    <= 1'b0;
          wb_regwrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (MEM_LAT=3 main instance, MEM_LAT=1 side instance).
// Instruction table drives the stage; expected writebacks are queued and popped by a monitor.
// Inputs are held while stall is high, as the upstream pipeline would.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_in, MemRead, MemWrite, RegWrite_in;
  logic [15:0] ALUOut, store_data;
  logic [2:0]  Rd_in;
  logic        stall, wb_valid, wb_regwrite;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;

  logic        v1, mr1, mw1, rw1;
  logic [15:0] alu1, sd1;
  logic [2:0]  rd1;
  logic        stall1, wb_valid1, wb_regwrite1;
  logic [15:0] wb_data1;
  logic [2:0]  wb_rd1;

  mem_stage #(.ADDR_W(8), .MEM_LAT(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOut(ALUOut),
    .store_data(store_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite_in(RegWrite_in), .Rd_in(Rd_in), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite)
  );

  mem_stage #(.ADDR_W(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(v1), .ALUOut(alu1),
    .store_data(sd1), .MemRead(mr1), .MemWrite(mw1),
    .RegWrite_in(rw1), .Rd_in(rd1), .stall(stall1),
    .wb_valid(wb_valid1), .wb_data(wb_data1), .wb_rd(wb_rd1), .wb_regwrite(wb_regwrite1)
  );

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic [15:0] sd;
    logic        mr, mw, rw;
    logic [2:0]  rd;
    int          exp_stall;
    logic [15:0] exp_data;
    logic        exp_rw;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        rw;
  } wb_t;

  int   checks = 0;
  int   errors = 0;
  wb_t  exp_q[$];
  wb_t  mon_e;
  logic mon_en = 1'b0;
  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                              input logic mr, input logic mw, input logic rw, input logic [2:0] rd,
                              input int es, input logic [15:0] ed, input logic erw);
    vec_t t;
    t.v = v; t.alu = alu; t.sd = sd; t.mr = mr; t.mw = mw; t.rw = rw; t.rd = rd;
    t.exp_stall = es; t.exp_data = ed; t.exp_rw = erw;
    return t;
  endfunction

  // Present one instruction, hold it through the stall, queue its writeback.
  task automatic issue(input vec_t t, input string name);
    int n;
    wb_t e;
    @(negedge clk);
    valid_in = t.v; ALUOut = t.alu; store_data = t.sd;
    MemRead = t.mr; MemWrite = t.mw; RegWrite_in = t.rw; Rd_in = t.rd;
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(t.exp_stall));
    if (t.v) begin
      e.data = t.exp_data; e.rd = t.rd; e.rw = t.exp_rw;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; ALUOut = '0; store_data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite_in = 1'b0; Rd_in = '0;
  endtask

  // Scoreboard: every valid writeback must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb actual_data=%h required=none", wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", 32'(wb_data), 32'(mon_e.data));
          chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
          chk("wb_regwrite", 32'(wb_regwrite), 32'(mon_e.rw));
        end
      end else begin
        chk("bubble_regwrite", 32'(wb_regwrite), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v    alu       sd       mr   mw   rw   rd  stall data     rw
    tv[0]  = mk(1, 16'h0105, 16'hBEEF, 0, 1, 1, 3'd1, 2, 16'h0105, 0); // store
    tv[1]  = mk(1, 16'h0005, 16'h0000, 1, 0, 1, 3'd3, 2, 16'hBEEF, 1); // load after store
    tv[2]  = mk(1, 16'h1234, 16'h0000, 0, 0, 1, 3'd6, 0, 16'h1234, 1); // ALU
    tv[3]  = mk(0, 16'h0005, 16'h0000, 1, 0, 1, 3'd2, 0, 16'h0000, 0); // invalid slot
    tv[4]  = mk(1, 16'h0007, 16'h0000, 0, 1, 0, 3'd0, 2, 16'h0007, 0); // preload mem[7]=0
    tv[5]  = mk(1, 16'hFF10, 16'h0A0A, 0, 1, 0, 3'd0, 2, 16'hFF10, 0); // store, upper bits dropped
    tv[6]  = mk(1, 16'h0010, 16'h0000, 1, 0, 1, 3'd2, 2, 16'h0A0A, 1); // load
    tv[7]  = mk(1, 16'h0020, 16'h7777, 1, 1, 1, 3'd4, 2, 16'h0020, 0); // both bits: store wins
    tv[8]  = mk(1, 16'h0120, 16'h0000, 1, 0, 1, 3'd5, 2, 16'h7777, 1); // wrapped address load
    tv[9]  = mk(1, 16'h0005, 16'h0000, 1, 0, 1, 3'd1, 2, 16'hBEEF, 1); // load
    tv[10] = mk(1, 16'h0010, 16'h0000, 1, 0, 1, 3'd2, 2, 16'h0A0A, 1); // load
    tv[11] = mk(1, 16'hABCD, 16'h0000, 0, 0, 1, 3'd7, 0, 16'hABCD, 1); // ALU
    tv[12] = mk(1, 16'h0042, 16'h0000, 0, 0, 0, 3'd0, 0, 16'h0042, 0); // ALU, no regwrite

    idle_inputs();
    v1 = 1'b0; alu1 = '0; sd1 = '0; mr1 = 1'b0; mw1 = 1'b0; rw1 = 1'b0; rd1 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) issue(tv[i], $sformatf("vec%0d", i));
    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset during the second busy cycle of a store to 0x07 must abort it.
    @(negedge clk);
    valid_in = 1'b1; ALUOut = 16'h0007; store_data = 16'h5555; MemWrite = 1'b1;
    #1 chk("abort_stall_c0", 32'(stall), 32'd1);
    @(negedge clk);
    #1 chk("abort_stall_c1", 32'(stall), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_wb_valid", 32'(wb_valid), 32'd0);
    chk("abort_wb_data", 32'(wb_data), 32'd0);
    chk("abort_wb_rd", 32'(wb_rd), 32'd0);
    chk("abort_wb_regwrite", 32'(wb_regwrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(mk(1, 16'h0007, 16'h0000, 1, 0, 1, 3'd5, 2, 16'h0000, 1), "abort_reload");
    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Single-cycle build: store then load of the same address, never stalling.
    @(negedge clk);
    v1 = 1'b1; alu1 = 16'h0033; sd1 = 16'hCAFE; mw1 = 1'b1; rw1 = 1'b1; rd1 = 3'd4;
    #1 chk("lat1_store_stall", 32'(stall1), 32'd0);
    @(posedge clk);
    #1;
    chk("lat1_store_valid", 32'(wb_valid1), 32'd1);
    chk("lat1_store_data", 32'(wb_data1), 32'h0033);
    chk("lat1_store_regwrite", 32'(wb_regwrite1), 32'd0);
    @(negedge clk);
    mw1 = 1'b0; mr1 = 1'b1; rd1 = 3'd2;
    #1 chk("lat1_load_stall", 32'(stall1), 32'd0);
    @(posedge clk);
    #1;
    chk("lat1_load_valid", 32'(wb_valid1), 32'd1);
    chk("lat1_load_data", 32'(wb_data1), 32'hCAFE);
    chk("lat1_load_rd", 32'(wb_rd1), 32'd2);
    chk("lat1_load_regwrite", 32'(wb_regwrite1), 32'd1);
    @(negedge clk);
    v1 = 1'b0; mr1 = 1'b0;
    @(posedge clk);
    #1 chk("lat1_bubble", 32'(wb_valid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipelined processor, directly downstream of the execute stage.
- Consumes the ALU result, the forwarded store operand and the memory/writeback control bits.
- Performs data-memory reads and writes with a parameterised access latency, asserting a pipeline stall while an access is in flight.
- Owns the MEM/WB pipeline register that feeds writeback and the forwarding mux.

Parameters:
- ADDR_W, 8, data-memory word-address width (depth 2^ADDR_W words of 16 bits).
- MEM_LAT, 3, cycles a load/store occupies the stage (minimum 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- valid_in  in  1  execute-stage slot holds a real instruction.
- ALUOut  in  16  ALU result: effective address for loads/stores, result otherwise.
- store_data  in  16  forwarded Bus2 value to store.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- RegWrite_in  in  1  instruction writes the register file.
- Rd_in  in  3  destination register.
- stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM while high.
- wb_valid  out  1  MEM/WB slot valid.
- wb_data  out  16  load data or passed ALU result.
- wb_rd  out  3  destination register.
- wb_regwrite  out  1  register-file write enable for writeback.

Behaviour:
- Reset: state IDLE, latency counter 0, stall 0, all wb_* outputs 0. Memory contents are not cleared.
- Address: word address = ALUOut[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo depth.
- memop = valid_in & (MemRead | MemWrite). When both bits are set, MemWrite wins: store performed, wb_data = ALUOut.
- Non-memory instruction in IDLE, or memop when MEM_LAT = 1:
  - Latency 1. On the next edge: wb_valid = valid_in, wb_rd = Rd_in, wb_regwrite = RegWrite_in & valid_in.
  - wb_data = mem[addr] for a load, otherwise ALUOut.
  - A store commits at that same edge. stall stays 0.
- Memop in IDLE with MEM_LAT > 1:
  - stall = 1 combinationally in that cycle.
  - At the edge: latch addr, store_data and the control bits into holding registers; cnt <= MEM_LAT-2; go to BUSY; MEM/WB loads a bubble (wb_valid = 0, wb_regwrite = 0).
- BUSY state:
  - Inputs are ignored; holding registers are used.
  - While cnt != 0: stall = 1, cnt decrements each cycle, MEM/WB loads a bubble.
  - When cnt == 0: stall = 0. At the edge, a store commits to the array, MEM/WB loads the held instruction (load data read from the array at that edge), and the state returns to IDLE.
  - Upstream advances on that same edge, so the held op is consumed exactly once.
- Stall length per memop = MEM_LAT-1 cycles. Back-to-back memops each pay the full latency with no overlap.
- Stores always drive wb_regwrite = 0, regardless of RegWrite_in.
- Load to the address just stored by the previous instruction returns the new value (store committed at an earlier edge).
- Invalid slot (valid_in = 0): no memory access, bubble into MEM/WB, no stall.
- Reset asserted in BUSY: the access is aborted, no write commits, state goes to IDLE, stall = 0 in the cycle after the reset edge.
- States: IDLE, BUSY. Unreachable encodings go to IDLE.

Decomposition:
- Shared package holds:
  - state enum (IDLE, BUSY);
  - data width constant DATA_W = 16;
  - register-index width REG_W = 3.
- One natural sub-module, data_memory:
  - 2^ADDR_W x 16 array;
  - synchronous write with enable;
  - combinational read;
  - no reset.
- The FSM, counter, holding registers and MEM/WB register live in mem_stage.

Test Plan:
- MEM_LAT = 3, store: ALUOut = 0x0105, store_data = 0xBEEF, MemWrite = 1 -> stall high for exactly 2 cycles, then mem[0x05] = 0xBEEF, wb_regwrite = 0, wb_valid = 1 in the completion cycle.
- Load following that store: ALUOut = 0x0005, MemRead = 1, RegWrite_in = 1, Rd_in = 3 -> 2 stall cycles, then wb_data = 0xBEEF, wb_rd = 3, wb_regwrite = 1.
- ALU instruction: ALUOut = 0x1234, RegWrite_in = 1, Rd_in = 6 -> no stall; next edge wb_data = 0x1234, wb_rd = 6.
- Reset in the second BUSY cycle of a store to address 0x07 (mem[0x07] preloaded 0x0000) -> mem[0x07] stays 0x0000, stall = 0, all wb_* = 0 after the reset edge.
- Back-to-back load, load, ALU -> stall pattern 1,1,0,1,1,0,0; three wb_valid pulses in program order, no duplicates.
- MEM_LAT = 1 build: store followed by a load at the same address -> never stalls; load returns the stored value one cycle after the store.
